uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the clk_i frequency used only by the divisor table comments and checks.
REQ-002 SHALL have port clk_i  input  1  system clock, driven from the BUFG output.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port baud_i  input  4  baud-rate select code.
REQ-005 SHALL have port eight_i  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 SHALL have port parity_en_i  input  1  1 = parity bit sent.
REQ-007 SHALL have port ohel_i  input  1  parity sense, 1 = odd, 0 = even.
REQ-008 SHALL have port data_i  input  8  byte to send, LSB first; bit 7 ignored when eight_i = 0.
REQ-009 SHALL have port load_i  input  1  load strobe; accepted only when tx_rdy_o = 1.
REQ-010 SHALL have port tx_rdy_o  output  1  ready to accept a byte.
REQ-011 SHALL have port tx_o  output  1  serial line, idle high, registered; feeds the tx OBUF.

Function
REQ-012 SHALL map baud_i to a bit period in clk_i cycles: 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736, 8:868, 9:434, 10:217, 11:109; codes 12-15 SHALL use 868.
REQ-013 SHALL always send an 11-bit frame: start(0), 7 or 8 data bits LSB first, parity if enabled, then stop bits (1) padding the frame to 11 bits.
REQ-014 Frame layouts SHALL be: 8+P = S,D0-D7,P,1; 8 only = S,D0-D7,1,1; 7+P = S,D0-D6,P,1,1; 7 only = S,D0-D6,1,1,1.
REQ-015 Parity SHALL be the XOR of the sent data bits, inverted when ohel_i = 1.
REQ-016 SHALL use a two-state FSM: IDLE (tx_o = 1, tx_rdy_o = 1) and SEND (tx_rdy_o = 0).
REQ-017 IDLE -> SEND on a clock edge where load_i = 1; on that edge the 11-bit frame SHALL be built into a shift register, with baud_i, eight_i, parity_en_i, ohel_i and data_i sampled.
REQ-018 tx_o SHALL go low (start bit) on the first cycle after acceptance; each bit SHALL be held for exactly one bit period.
REQ-019 SEND -> IDLE when the 11th bit period expires; tx_rdy_o SHALL rise exactly 11 x period cycles after the acceptance edge.
REQ-020 load_i during SEND SHALL be ignored, not queued; load_i on the same edge tx_rdy_o rises SHALL NOT be accepted, but load_i on the next cycle SHALL be.
REQ-021 Changes to the configuration inputs or data_i during SEND SHALL NOT affect the frame in flight.
REQ-022 The bit-period counter SHALL be 19 bits, count down from period-1 to 0, and reload on each bit boundary; the bit counter SHALL be 4 bits, counting 0-10.

Reset
REQ-023 While rst_i = 0: state = IDLE, tx_o = 1, tx_rdy_o = 1, all counters and the shift register cleared to 0; the idle-high shift register fill SHALL take effect on the next load.
REQ-024 Reset asserted mid-frame SHALL return tx_o to 1 immediately, asynchronously, and drop the frame.

Structure
REQ-025 SHALL place the baud divisor table, the 4-bit select type, the frame length constant (11), and the FSM state enum in shared package uart_pkg, which the receiver also uses.
REQ-026 SHALL instantiate one sub-module, uart_baud_tick: a loadable down-counter producing a one-cycle tick at the end of each bit period.

Verification
REQ-027 baud_i=8, eight_i=1, parity_en_i=1, ohel_i=0, data_i=0x55, load -> tx_o = 0,1,0,1,0,1,0,1,0,0,1 at 868 cycles/bit; tx_rdy_o high again after 9548 cycles.
REQ-028 baud_i=11, eight_i=0, parity_en_i=1, ohel_i=1, data_i=0x41 -> S=0, D=1,0,0,0,0,0,1, P=1, then 1,1 at 109 cycles/bit.
REQ-029 eight_i=1, parity_en_i=0, data_i=0xFF, then load_i pulsed mid-frame with data_i=0x00 -> frame = 0,1x8,1,1; second load ignored; tx_o stays 1 afterwards.
REQ-030 Back-to-back test: load held high continuously -> second start bit begins 1 cycle after tx_rdy_o rises; the second frame is intact.
REQ-031 rst_i pulsed low at bit 4 of a frame -> tx_o = 1 and tx_rdy_o = 1 within the reset; the next load sends a full, correct frame.
REQ-032 baud_i=13 -> bit period = 868 cycles; baud_i changed to 0 mid-frame -> period stays 868 until the frame ends.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select type, divisor table, frame length and FSM states.
// The receiver imports the same package.
package uart_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned CNT_W      = 19;

    typedef logic [3:0] baud_sel_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_t;

    // Bit period in clk cycles at 100 MHz: round(100e6 / baud), baud = 300 .. 921600.
    function automatic logic [CNT_W-1:0] baud_period(input baud_sel_t sel);
        logic [CNT_W-1:0] p;
        case (sel)
            4'd0:    p = 19'd333333;
            4'd1:    p = 19'd83333;
            4'd2:    p = 19'd41667;
            4'd3:    p = 19'd20833;
            4'd4:    p = 19'd10417;
            4'd5:    p = 19'd5208;
            4'd6:    p = 19'd2604;
            4'd7:    p = 19'd1736;
            4'd8:    p = 19'd868;
            4'd9:    p = 19'd434;
            4'd10:   p = 19'd217;
            4'd11:   p = 19'd109;
            default: p = 19'd868;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side bundle for uart_tx: configuration, byte/load handshake and the serial line.
interface uart_tx_if;
    import uart_pkg::*;

    baud_sel_t  baud;
    logic       eight;
    logic       parity_en;
    logic       ohel;
    logic [7:0] data;
    logic       load;
    logic       tx_rdy;
    logic       tx;

    modport master (
        output baud, eight, parity_en, ohel, data, load,
        input  tx_rdy, tx
    );

    modport slave (
        input  baud, eight, parity_en, ohel, data, load,
        output tx_rdy, tx
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Loadable down-counter: one-cycle tick_o at the end of every bit period while enabled.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             en_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] reload_q;

    // The period is latched at load so later baud changes cannot reach a frame in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else if (load_i) begin
            cnt_q    <= period_i - 19'd1;
            reload_q <= period_i - 19'd1;
        end else if (en_i) begin
            if (cnt_q == '0) cnt_q <= reload_q;
            else             cnt_q <= cnt_q - 19'd1;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: fixed 11-bit frame (start, 7/8 data LSB first, optional parity, stop fill).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  baud_sel_t  baud_i,
    input  logic       eight_i,
    input  logic       parity_en_i,
    input  logic       ohel_i,
    input  logic [7:0] data_i,
    input  logic       load_i,
    output logic       tx_rdy_o,
    output logic       tx_o
);

    if (CLK_HZ != 100_000_000) begin : g_clk_check
        $error("uart_tx: divisor table assumes a 100 MHz clk_i");
    end

    tx_state_t                 state_q;
    logic [FRAME_BITS-1:0]     frame_q, frame_d;
    logic [3:0]                bit_cnt_q;
    logic                      tx_q, rdy_q;
    logic                      parity;
    logic                      accept;
    logic                      tick;

    assign accept = (state_q == ST_IDLE) && load_i;

    always_comb begin
        parity  = (^data_i[6:0]) ^ (eight_i & data_i[7]) ^ ohel_i;
        frame_d = '1;
        case ({eight_i, parity_en_i})
            2'b11:   frame_d = {1'b1,   parity, data_i,      1'b0};
            2'b10:   frame_d = {2'b11,          data_i,      1'b0};
            2'b01:   frame_d = {2'b11,  parity, data_i[6:0], 1'b0};
            default: frame_d = {3'b111,         data_i[6:0], 1'b0};
        endcase
    end

    uart_baud_tick u_baud_tick (
        .clk_i    (clk_i),
        .rst_ni   (rst_i),
        .load_i   (accept),
        .period_i (baud_period(baud_i)),
        .en_i     (state_q == ST_SEND),
        .tick_o   (tick)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_i) begin
                        frame_q   <= frame_d;
                        tx_q      <= frame_d[0];
                        bit_cnt_q <= '0;
                        rdy_q     <= 1'b0;
                        state_q   <= ST_SEND;
                    end
                end
                default: begin
                    if (tick) begin
                        if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                            tx_q      <= 1'b1;
                            rdy_q     <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            // tx_q already holds frame_q[0]; the next bit sits at index 1.
                            tx_q      <= frame_q[1];
                            frame_q   <= {1'b1, frame_q[FRAME_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign tx_o     = tx_q;
    assign tx_rdy_o = rdy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx against a bit-list frame model.
module tb_uart_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_if bus ();

    uart_tx #(.CLK_HZ(100_000_000)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .baud_i      (bus.baud),
        .eight_i     (bus.eight),
        .parity_en_i (bus.parity_en),
        .ohel_i      (bus.ohel),
        .data_i      (bus.data),
        .load_i      (bus.load),
        .tx_rdy_o    (bus.tx_rdy),
        .tx_o        (bus.tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned period_of(input int unsigned code);
        int unsigned tbl [12] = '{333333, 83333, 41667, 20833, 10417, 5208,
                                  2604, 1736, 868, 434, 217, 109};
        return (code < 12) ? tbl[code] : 868;
    endfunction

    // Line order: start 0, data LSB first, parity (if any), then 1s up to 11 bits.
    function automatic logic [10:0] ref_frame(input logic eight, input logic pe,
                                              input logic odd, input logic [7:0] d);
        bit          q[$];
        int unsigned ones = 0;
        int unsigned n    = eight ? 8 : 7;
        logic [10:0] f;
        q.push_back(1'b0);
        for (int unsigned i = 0; i < n; i++) begin
            q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe) q.push_back(((ones % 2) == 1) ^ odd);
        while (q.size() < 11) q.push_back(1'b1);
        for (int unsigned i = 0; i < 11; i++) f[i] = q[i];
        return f;
    endfunction

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int unsigned code, input logic eight, input logic pe,
                               input logic odd, input logic [7:0] d, input bit hold);
        int unsigned guard = 0;
        while (bus.tx_rdy !== 1'b1 && guard < 30000) begin
            cycles(1);
            guard++;
        end
        chk("rdy_before_load", bus.tx_rdy, 1'b1);
        bus.baud      = 4'(code);
        bus.eight     = eight;
        bus.parity_en = pe;
        bus.ohel      = odd;
        bus.data      = d;
        bus.load      = 1'b1;
        cycles(1);
        if (!hold) bus.load = 1'b0;
    endtask

    // Entered one step after the acceptance edge; leaves one step after tx_rdy should rise.
    task automatic check_frame(input string tag, input logic [10:0] exp, input int unsigned p);
        for (int unsigned k = 0; k < 11; k++) begin
            chk($sformatf("%s_b%0d_first", tag, k), bus.tx, exp[k]);
            chk($sformatf("%s_b%0d_busy", tag, k), bus.tx_rdy, 1'b0);
            cycles(p - 1);
            chk($sformatf("%s_b%0d_last", tag, k), bus.tx, exp[k]);
            if (k == 10) chk($sformatf("%s_rdy_early", tag), bus.tx_rdy, 1'b0);
            cycles(1);
        end
        chk($sformatf("%s_rdy_rise", tag), bus.tx_rdy, 1'b1);
        chk($sformatf("%s_idle_tx", tag), bus.tx, 1'b1);
    endtask

    initial begin
        logic [7:0]  d1, d2;
        logic [10:0] e1;
        logic        r8, rp, ro;
        int unsigned rb;

        bus.baud = 4'd8; bus.eight = 1'b1; bus.parity_en = 1'b0;
        bus.ohel = 1'b0; bus.data = 8'h00; bus.load = 1'b0;
        cycles(3);
        chk("reset_tx", bus.tx, 1'b1);
        chk("reset_rdy", bus.tx_rdy, 1'b1);
        rst_n = 1'b1;
        cycles(2);

        // 8 data + even parity at 868 cycles/bit
        start_frame(8, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
        check_frame("b8_8p_55", ref_frame(1'b1, 1'b1, 1'b0, 8'h55), period_of(8));

        // 7 data + odd parity at 109 cycles/bit
        start_frame(11, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0);
        check_frame("b11_7p_41", ref_frame(1'b0, 1'b1, 1'b1, 8'h41), period_of(11));

        // mid-frame load is ignored, line stays idle afterwards
        start_frame(11, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        fork
            check_frame("ignore_ld", ref_frame(1'b1, 1'b0, 1'b0, 8'hFF), period_of(11));
            begin
                cycles(3 * 109 + 50);
                bus.data = 8'h00;
                bus.load = 1'b1;
                cycles(1);
                bus.load = 1'b0;
            end
        join
        for (int unsigned i = 0; i < 4; i++) begin
            cycles(150);
            chk("after_ignore_tx", bus.tx, 1'b1);
            chk("after_ignore_rdy", bus.tx_rdy, 1'b1);
        end

        // code 13 maps to 868; config and data changes mid-frame do not leak in
        d1 = 8'($urandom);
        start_frame(13, 1'b1, 1'b1, 1'b1, d1, 1'b0);
        fork
            check_frame("b13_freeze", ref_frame(1'b1, 1'b1, 1'b1, d1), 868);
            begin
                cycles(3 * 868 + 10);
                bus.baud = 4'd0; bus.eight = 1'b0; bus.parity_en = 1'b0;
                bus.ohel = 1'b0; bus.data = ~d1;
            end
        join

        // load held high: second frame starts one cycle after tx_rdy rises
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        start_frame(11, 1'b1, 1'b1, 1'b0, d1, 1'b1);
        check_frame("b2b_first", ref_frame(1'b1, 1'b1, 1'b0, d1), 109);
        bus.data = d2;
        bus.ohel = 1'b1;
        cycles(1);
        bus.load = 1'b0;
        check_frame("b2b_second", ref_frame(1'b1, 1'b1, 1'b1, d2), 109);

        // asynchronous reset in the middle of bit 4 (D3 forced to 0)
        d1 = 8'($urandom) & 8'hF7;
        e1 = ref_frame(1'b1, 1'b0, 1'b0, d1);
        start_frame(11, 1'b1, 1'b0, 1'b0, d1, 1'b0);
        cycles(4 * 109 + 50);
        chk("pre_reset_bit4", bus.tx, e1[4]);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_tx", bus.tx, 1'b1);
        chk("async_reset_rdy", bus.tx_rdy, 1'b1);
        cycles(2);
        chk("held_reset_tx", bus.tx, 1'b1);
        rst_n = 1'b1;
        cycles(2);
        d2 = 8'($urandom);
        start_frame(11, 1'b0, 1'b1, 1'b0, d2, 1'b0);
        check_frame("post_reset", ref_frame(1'b0, 1'b1, 1'b0, d2), 109);

        // randomized frames at the faster rates
        for (int unsigned n = 0; n < 6; n++) begin
            rb = $urandom_range(9, 11);
            r8 = 1'($urandom);
            rp = 1'($urandom);
            ro = 1'($urandom);
            d1 = 8'($urandom);
            start_frame(rb, r8, rp, ro, d1, 1'b0);
            check_frame($sformatf("rand%0d", n), ref_frame(r8, rp, ro, d1), period_of(rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
